// File: rtl/pipe_vect_skid.sv
// ============================================================================
// Module   : pipe_vect_skid
// Brief    : Two-entry skid-buffered pipeline stage for a scalar + two vectors.
//            Optional synchronous flush enabled by macro PIPE_VECT_FLUSH_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_vect_skid #(
  parameter int WIDTH        = 8,
  parameter int registerSize = 8,
  parameter int vectorSize   = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [WIDTH-1:0]                       in,
  input  logic [vectorSize-1:0][registerSize-1:0] vect1,
  input  logic [vectorSize-1:0][registerSize-1:0] vect2,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic [WIDTH-1:0]                       out,
  output logic [vectorSize-1:0][registerSize-1:0] vect1_out,
  output logic [vectorSize-1:0][registerSize-1:0] vect2_out,
  output logic                                   out_valid,
`ifdef PIPE_VECT_FLUSH_EN
  input  logic                                   flush,
`endif
  input  logic                                   out_ready
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]                               r_state;
  logic [1:0]                               w_state_nxt;
  logic                                     r_in_ready;
  logic                                     r_out_valid;
  logic [WIDTH-1:0]                         r_out;
  logic [vectorSize-1:0][registerSize-1:0] r_v1;
  logic [vectorSize-1:0][registerSize-1:0] r_v2;
  logic [WIDTH-1:0]                         r_s_out;
  logic [vectorSize-1:0][registerSize-1:0] r_s_v1;
  logic [vectorSize-1:0][registerSize-1:0] r_s_v2;
  logic                                     w_accept;
  logic                                     w_emit;
  logic                                     w_flush;

`ifdef PIPE_VECT_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_accept = in_valid & r_in_ready;
  assign w_emit   = r_out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    if (w_flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_accept) w_state_nxt = S_ONE;
        S_ONE: begin
          if (w_accept && !w_emit)      w_state_nxt = S_TWO;
          else if (!w_accept && w_emit) w_state_nxt = S_EMPTY;
        end
        S_TWO:   if (w_emit) w_state_nxt = S_ONE;
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // Handshake flags are registered from the next state so in_ready never
  // depends combinationally on out_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != S_TWO);
      r_out_valid <= (w_state_nxt != S_EMPTY);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out   <= '0;
      r_v1    <= '0;
      r_v2    <= '0;
      r_s_out <= '0;
      r_s_v1  <= '0;
      r_s_v2  <= '0;
    end else if (!w_flush) begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_out <= in;
            r_v1  <= vect1;
            r_v2  <= vect2;
          end
        end
        S_ONE: begin
          if (w_accept && w_emit) begin
            r_out <= in;
            r_v1  <= vect1;
            r_v2  <= vect2;
          end else if (w_accept) begin
            r_s_out <= in;
            r_s_v1  <= vect1;
            r_s_v2  <= vect2;
          end
        end
        S_TWO: begin
          if (w_emit) begin
            r_out <= r_s_out;
            r_v1  <= r_s_v1;
            r_v2  <= r_s_v2;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign vect1_out = r_v1;
  assign vect2_out = r_v2;

endmodule

`default_nettype wire

// File: tb/tb_pipe_vect_skid.sv
// Scoreboard bench for pipe_vect_skid: queue model of held entries checks
// handshake flags and payload every cycle; directed cases then random traffic.
`default_nettype none

module tb_pipe_vect_skid;

  localparam int PW = 8 + 2 * 4 * 8;

  logic              clk;
  logic              reset;
  logic [7:0]        in_d;
  logic [3:0][7:0]   v1;
  logic [3:0][7:0]   v2;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        out_d;
  logic [3:0][7:0]   v1_o;
  logic [3:0][7:0]   v2_o;
  logic              out_valid;
  logic              out_ready;
  logic              flush;

  int                n_checks = 0;
  int                n_errors = 0;
  logic [PW-1:0]     q[$];

  pipe_vect_skid #(.WIDTH(8), .registerSize(8), .vectorSize(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in_d),
    .vect1     (v1),
    .vect2     (v2),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out_d),
    .vect1_out (v1_o),
    .vect2_out (v2_o),
    .out_valid (out_valid),
`ifdef PIPE_VECT_FLUSH_EN
    .flush     (flush),
`endif
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Called just after a negedge with inputs already driven; advances one cycle.
  task automatic cycle();
    bit acc, emt;
    chk("out_valid", PW'(out_valid), PW'(q.size() > 0));
    chk("in_ready",  PW'(in_ready),  PW'(q.size() < 2));
    if (q.size() > 0) chk("payload", {out_d, v1_o, v2_o}, q[0]);
    acc = in_valid && (q.size() < 2);
    emt = (q.size() > 0) && out_ready;
    if (flush) begin
      q.delete();
    end else begin
      if (emt) void'(q.pop_front());
      if (acc) q.push_back({in_d, v1, v2});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_payload",   {out_d, v1_o, v2_o}, '0);
    chk("rst_out_valid", PW'(out_valid), PW'(0));
    chk("rst_in_ready",  PW'(in_ready),  PW'(1));
    q.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive(input logic vld, input logic [7:0] d, input logic rdy);
    in_valid  = vld;
    in_d      = d;
    v1        = {d, d + 8'd1, d + 8'd2, d + 8'd3};
    v2        = ~{d, d + 8'd1, d + 8'd2, d + 8'd3};
    out_ready = rdy;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    do_reset();

    // First-payload latency with explicit vector lanes
    in_d = 8'h11; v1 = {8'd1, 8'd2, 8'd3, 8'd4}; v2 = 32'hCAFE_F00D;
    in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    drive(1'b0, 8'h00, 1'b1);
    cycle();
    cycle();

    // Fill both entries under stall; third push must be ignored
    drive(1'b1, 8'hA0, 1'b0); cycle();
    drive(1'b1, 8'hB0, 1'b0); cycle();
    drive(1'b1, 8'hC0, 1'b0); cycle();
    cycle();
    drive(1'b0, 8'h00, 1'b1); cycle(); cycle(); cycle();

    // Back-to-back streaming
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i), 1'b1);
      cycle();
    end
    drive(1'b0, 8'h00, 1'b1); cycle(); cycle();

    // Asynchronous reset while holding two entries
    drive(1'b1, 8'hA1, 1'b0); cycle();
    drive(1'b1, 8'hB1, 1'b0); cycle();
    drive(1'b0, 8'h00, 1'b0);
    do_reset();
    drive(1'b1, 8'hD0, 1'b1); cycle();
    drive(1'b0, 8'h00, 1'b1); cycle(); cycle();

`ifdef PIPE_VECT_FLUSH_EN
    drive(1'b1, 8'hA2, 1'b0); cycle();
    drive(1'b1, 8'hB2, 1'b0); cycle();
    drive(1'b1, 8'hC2, 1'b1); flush = 1'b1; cycle();
    flush = 1'b0;
    drive(1'b0, 8'h00, 1'b1); cycle(); cycle();
`endif

    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      cycle();
    end
    drive(1'b0, 8'h00, 1'b1); cycle(); cycle(); cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_vect_skid.md
PIPE_VECT_SKID -- requirements
Module: pipe_vect_skid

Interface
REQ-001 Parameter WIDTH, default 8, scalar payload width.
REQ-002 Parameter registerSize, default 8, bits per vector lane.
REQ-003 Parameter vectorSize, default 4, lanes per vector.
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in  input  WIDTH  scalar payload from upstream.
REQ-007 vect1, vect2  input  [vectorSize-1:0][registerSize-1:0]  vector payloads from upstream.
REQ-008 in_valid  input  1  upstream payload valid.
REQ-009 in_ready  output  1  stage can accept; registered (no combinational path from out_ready).
REQ-010 out  output  WIDTH  scalar payload to downstream.
REQ-011 vect1_out, vect2_out  output  [vectorSize-1:0][registerSize-1:0]  vector payloads to downstream.
REQ-012 out_valid  output  1  downstream payload valid.
REQ-013 out_ready  input  1  downstream accepts.
REQ-014 flush  input  1  synchronous discard of held entries (present only with PIPE_VECT_FLUSH_EN).

Function
REQ-015 Accept = in_valid & in_ready; emit = out_valid & out_ready; the payload is {in, vect1, vect2} moved as one unit.
REQ-016 Storage SHALL be a main register (drives outputs) plus one skid register.
REQ-017 FSM states: EMPTY (0 held), ONE (main valid), TWO (main+skid valid).
REQ-018 EMPTY: accept -> ONE, payload to main; else stay.
REQ-019 ONE: accept & emit -> ONE, main loads new payload; accept only -> TWO, payload to skid; emit only -> EMPTY; neither -> stay.
REQ-020 TWO: emit -> ONE, main loads skid; no accept possible (in_ready=0); else stay.
REQ-021 in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO.
REQ-022 out_valid SHALL be 1 in ONE and TWO, 0 in EMPTY.
REQ-023 Latency: payload accepted at edge N SHALL appear on outputs after edge N when main is empty or emptied at the same edge.
REQ-024 Ordering SHALL be strict FIFO; no payload dropped or duplicated absent flush/reset.
REQ-025 Outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 Payload bits SHALL pass unmodified; no arithmetic.
REQ-027 in_valid while in_ready=0 SHALL be ignored.

Reset
REQ-028 reset=1 SHALL immediately force state EMPTY, out=0, vect1_out=0, vect2_out=0, skid=0, out_valid=0, in_ready=1.
REQ-029 Reset mid-operation SHALL discard all held payloads; the first accept after release is the first emitted.

Configuration
REQ-030 Macro PIPE_VECT_FLUSH_EN defined: flush port exists; flush=1 at an edge -> EMPTY, out_valid=0, in_ready=1 next cycle; accept and emit at that edge are discarded (flush wins); payload registers keep their values.
REQ-031 Macro undefined: no flush port; behaviour per REQ-015..REQ-027 only.

Verification
REQ-032 Reset then in=8'h11, vect1={1,2,3,4}, in_valid=1, out_ready=1 -> next cycle out=8'h11, vect1_out={1,2,3,4}, out_valid=1.
REQ-033 out_ready=0, push A=8'hA0, B=8'hB0 -> in_ready=0 after B; third push C ignored; out_ready=1 -> A, B emitted in order, in_ready=1 after A.
REQ-034 Continuous in_valid=1, out_ready=1, payload incrementing 0..15 -> out 0..15 one per cycle, no bubbles after first.
REQ-035 State TWO holding A,B, assert reset mid-cycle -> out=0, vect outputs 0, out_valid=0 before next edge; post-release push D -> D is first emitted.
REQ-036 With PIPE_VECT_FLUSH_EN: hold A,B, flush=1 with in_valid=1 payload C -> next cycle out_valid=0, in_ready=1, C not emitted.
REQ-037 Random in_valid/out_ready, 10k cycles -> scoreboard: order preserved, outputs stable under stall.
